// File: rtl/in1_debouncer_pkg.sv
// Shared types and constants for the In1 debouncer: FSM state encoding,
// the minimum legal debounce length and the glitch counter geometry.
package in1_debouncer_pkg;

    typedef enum logic [1:0] {
        S_LOW    = 2'b00,
        S_CHK_HI = 2'b01,
        S_HIGH   = 2'b10,
        S_CHK_LO = 2'b11
    } state_t;

    localparam int DEBOUNCE_MIN = 2;
    localparam int GLITCH_W     = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] val);
        return (val == GLITCH_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// clear to 0 on the active-low asynchronous reset.
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/in1_debouncer.sv
// Synchronises and debounces the raw In1 input, emitting rise/fall pulses.
// Define IN1_DEBOUNCER_GLITCH_CNT_EN to add the saturating GlitchCnt output.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_LOW    | output low, synchronised input low
// S_CHK_HI | output low, counting consecutive high samples
// S_HIGH   | output high, synchronised input high
// S_CHK_LO | output high, counting consecutive low samples
module in1_debouncer
    import in1_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic RawIn,
    output logic Out1,
    output logic RisePulse,
    output logic FallPulse
`ifdef IN1_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] GlitchCnt
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
            $error("in1_debouncer: DEBOUNCE_CYCLES must be in 2..65535");
        end
    endgenerate

    logic       s2;
    state_t     state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (RawIn),
        .q   (s2)
    );

    // cnt counts samples already seen at the new level, so the edge that
    // sees the D-th matching sample is the one where cnt == D-1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_LOW;
            cnt       <= '0;
            Out1      <= 1'b0;
            RisePulse <= 1'b0;
            FallPulse <= 1'b0;
        end else begin
            RisePulse <= 1'b0;
            FallPulse <= 1'b0;
            case (state)
                S_LOW: begin
                    if (s2) begin
                        state <= S_CHK_HI;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_CHK_HI: begin
                    if (!s2) begin
                        state <= S_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_HIGH;
                        Out1      <= 1'b1;
                        RisePulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!s2) begin
                        state <= S_CHK_LO;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_CHK_LO: begin
                    if (s2) begin
                        state <= S_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_LOW;
                        Out1      <= 1'b0;
                        FallPulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    Out1  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IN1_DEBOUNCER_GLITCH_CNT_EN
    logic abort;

    assign abort = (state == S_CHK_HI && !s2) || (state == S_CHK_LO && s2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            GlitchCnt <= '0;
        end else if (abort) begin
            GlitchCnt <= glitch_sat_inc(GlitchCnt);
        end
    end
`endif

endmodule

// File: tb/tb_in1_debouncer.sv
// Scoreboard bench for in1_debouncer: expected Out1 edges are queued when
// RawIn segments are driven and checked when Out1 actually changes.
module tb_in1_debouncer;

    localparam int D = 4;

    typedef struct {
        int   cyc;
        logic val;
    } evt_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic RawIn = 1'b0;
    logic Out1;
    logic RisePulse;
    logic FallPulse;
`ifdef IN1_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] GlitchCnt;
`endif

    evt_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic exp_level = 1'b0;
    int   exp_glitch = 0;
    logic prev_out1 = 1'b0;
    logic mon_rise;
    logic mon_fall;
    evt_t mon_evt;

    in1_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
`ifdef IN1_DEBOUNCER_GLITCH_CNT_EN
        .GlitchCnt (GlitchCnt),
`endif
        .CLK       (CLK),
        .RST       (RST),
        .RawIn     (RawIn),
        .Out1      (Out1),
        .RisePulse (RisePulse),
        .FallPulse (FallPulse)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_glitch(input string tag);
`ifdef IN1_DEBOUNCER_GLITCH_CNT_EN
        chk(tag, 32'(GlitchCnt), 32'(exp_glitch));
`endif
    endtask

    // Drive RawIn=v so that exactly n sampling edges see it; queue the Out1
    // edge it must cause (first sample r, new level at edge r+D+1).
    task automatic seg(input logic v, input int n);
        int r;
        @(negedge CLK);
        RawIn = v;
        r = cyc + 1;
        if (v != exp_level) begin
            if (n >= D) begin
                sb_q.push_back('{r + D + 1, v});
                exp_level = v;
            end else if (exp_glitch < 255) begin
                exp_glitch++;
            end
        end
        repeat (n - 1) @(negedge CLK);
    endtask

    // Output monitor: pulses must coincide with the first cycle of a new
    // Out1 level, and every Out1 change must match the queue head.
    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            prev_out1 = 1'b0;
        end else begin
            mon_rise = Out1 & ~prev_out1;
            mon_fall = ~Out1 & prev_out1;
            chk("rise_pulse", 32'(RisePulse), 32'(mon_rise));
            chk("fall_pulse", 32'(FallPulse), 32'(mon_fall));
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                chk("missed_edge_cyc", 32'(cyc), 32'(sb_q[0].cyc));
                void'(sb_q.pop_front());
            end
            if (mon_rise || mon_fall) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out1", 32'(Out1), 32'(prev_out1));
                end else begin
                    mon_evt = sb_q.pop_front();
                    chk("edge_cyc", 32'(cyc), 32'(mon_evt.cyc));
                    chk("edge_level", 32'(Out1), 32'(mon_evt.val));
                end
            end
            prev_out1 = Out1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r2;
        RST = 1'b0;
        RawIn = 1'b0;
        #1;
        chk("rst_out1", 32'(Out1), 32'd0);
        chk("rst_rise", 32'(RisePulse), 32'd0);
        chk("rst_fall", 32'(FallPulse), 32'd0);
        chk_glitch("rst_glitch");
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b1;

        // quiet after reset
        repeat (20) begin
            @(negedge CLK);
            chk("idle_out1", 32'(Out1), 32'd0);
            chk_glitch("idle_glitch");
        end

        // D-1 high samples: no change, one glitch
        seg(1'b1, D - 1);
        seg(1'b0, 12);
        chk("short_hi_out1", 32'(Out1), 32'd0);
        chk_glitch("short_hi_glitch");

        // held high, then exact-D boundary pulses and a short low glitch
        seg(1'b1, 20);
        seg(1'b0, D);
        seg(1'b1, D);
        seg(1'b0, D - 1);
        seg(1'b1, 12);
        chk("hi_after_glitch", 32'(Out1), 32'd1);
        chk_glitch("short_lo_glitch");

        // held low from stable high
        seg(1'b0, 20);
        chk("fall_out1", 32'(Out1), 32'd0);

        // reset mid-check, then full latency after release
        @(negedge CLK);
        RawIn = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rst_mid_out1", 32'(Out1), 32'd0);
        chk("rst_mid_rise", 32'(RisePulse), 32'd0);
        sb_q.delete();
        exp_level = 1'b0;
        exp_glitch = 0;
        chk_glitch("rst_mid_glitch");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b1;
        r2 = cyc + 1;
        sb_q.push_back('{r2 + D + 1, 1'b1});
        exp_level = 1'b1;
        repeat (20) @(negedge CLK);
        chk("post_rst_out1", 32'(Out1), 32'd1);

        // asynchronous reset while output is high
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        chk("rst_hi_out1", 32'(Out1), 32'd0);
        chk("rst_hi_fall", 32'(FallPulse), 32'd0);
        RawIn = 1'b0;
        exp_level = 1'b0;
        sb_q.delete();
        exp_glitch = 0;
        @(negedge CLK);
        #1 RST = 1'b1;
        repeat (10) @(negedge CLK);
        chk("rst_hi_stay_low", 32'(Out1), 32'd0);

        // glitch bursts: counter saturates, output never moves
        repeat (300) begin
            seg(1'b1, 3);
            seg(1'b0, 8);
        end
        chk("burst_out1", 32'(Out1), 32'd0);
        chk_glitch("burst_glitch_sat");

        repeat (10) @(negedge CLK);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        chk("final_out1", 32'(Out1), 32'(exp_level));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
